// File: rtl/ca_pipe_pkg.sv
// Shared pipeline-control definitions: register address width, hazard FSM
// state encoding and the width of the flush-cycle down-counter.
package ca_pipe_pkg;
  localparam int REG_ADDR_W  = 5;
  localparam int FLUSH_CNT_W = 4;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  // count up on inc, stick at all-ones, clear to zero on request
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                         cnt_o <= '0;
    else if (clr_i)                    cnt_o <= '0;
    else if (inc_i && (cnt_o != '1))   cnt_o <= cnt_o + 1'b1;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Front-end stall/flush sequencer: load-use detection, multi-cycle branch
// flush, memory-busy freeze, and saturating stall/flush counters.
module pipe_hazard_ctrl
  import ca_pipe_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] if_id_rs_i,
  input  logic [REG_ADDR_W-1:0] if_id_rt_i,
  input  logic                  id_ex_memread_i,
  input  logic [REG_ADDR_W-1:0] id_ex_rt_i,
  input  logic                  branch_taken_i,
  input  logic                  mem_busy_i,
  input  logic                  clr_cnt_i,
  output logic                  pc_write_o,
  output logic                  if_id_hazard_o,
  output logic                  if_id_flush_o,
  output logic                  id_ex_bubble_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [FLUSH_CNT_W-1:0] LAST_FLUSH   = FLUSH_CNT_W'(1);
  localparam bit                     MULTI_FLUSH  = (FLUSH_CYCLES > 1);

  state_t                 state, state_nxt;
  logic [FLUSH_CNT_W-1:0] flush_left, flush_left_nxt;
  logic                   load_use;

  // r0 is hardwired zero, so a load targeting it never creates a dependency
  assign load_use = id_ex_memread_i && (id_ex_rt_i != '0) &&
                    ((id_ex_rt_i == if_id_rs_i) || (id_ex_rt_i == if_id_rt_i));

  // state and remaining-flush register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= RUN;
      flush_left <= '0;
    end else begin
      state      <= state_nxt;
      flush_left <= flush_left_nxt;
    end
  end

  // next state: memory busy freezes everything; a stalled branch is dropped
  // because it will re-resolve once the load-use stall clears
  always_comb begin
    state_nxt      = state;
    flush_left_nxt = flush_left;
    if (!mem_busy_i) begin
      unique case (state)
        RUN: begin
          if (!load_use && branch_taken_i && MULTI_FLUSH) begin
            state_nxt      = FLUSH;
            flush_left_nxt = FLUSH_RELOAD;
          end
        end
        FLUSH: begin
          flush_left_nxt = flush_left - 1'b1;
          if (flush_left == LAST_FLUSH) state_nxt = RUN;
        end
        default: begin
          state_nxt      = RUN;
          flush_left_nxt = '0;
        end
      endcase
    end
  end

  // output priority mux: busy > ongoing flush > load-use > taken branch
  always_comb begin
    pc_write_o     = 1'b1;
    if_id_hazard_o = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_bubble_o = 1'b0;
    if (mem_busy_i) begin
      pc_write_o     = 1'b0;
      if_id_hazard_o = 1'b1;
    end else if (state == FLUSH) begin
      if_id_flush_o  = 1'b1;
    end else if (load_use) begin
      pc_write_o     = 1'b0;
      if_id_hazard_o = 1'b1;
      id_ex_bubble_o = 1'b1;
    end else if (branch_taken_i) begin
      if_id_flush_o  = 1'b1;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr_cnt_i),
    .inc_i (if_id_hazard_o),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr_cnt_i),
    .inc_i (if_id_flush_o),
    .cnt_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (3-cycle flush / 4-bit counters
// and 1-cycle flush / 32-bit counters) share stimulus and are compared each
// cycle against a behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs, rt, ert;
  logic       mr, br, busy, clr;

  logic        pw_a, hz_a, fl_a, bb_a;
  logic [3:0]  sc_a, fc_a;
  logic        pw_b, hz_b, fl_b, bb_b;
  logic [31:0] sc_b, fc_b;

  int nchk = 0;
  int nerr = 0;

  // model state, index 0 = instance a, 1 = instance b
  int    fcyc[2] = '{3, 1};
  longint cmax[2] = '{15, 64'hFFFF_FFFF};
  int    rem[2];
  longint m_sc[2], m_fc[2];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4)) dut_a (
    .clk_i(clk), .rst_i(rst), .if_id_rs_i(rs), .if_id_rt_i(rt),
    .id_ex_memread_i(mr), .id_ex_rt_i(ert), .branch_taken_i(br),
    .mem_busy_i(busy), .clr_cnt_i(clr), .pc_write_o(pw_a),
    .if_id_hazard_o(hz_a), .if_id_flush_o(fl_a), .id_ex_bubble_o(bb_a),
    .stall_cnt_o(sc_a), .flush_cnt_o(fc_a));

  pipe_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(32)) dut_b (
    .clk_i(clk), .rst_i(rst), .if_id_rs_i(rs), .if_id_rt_i(rt),
    .id_ex_memread_i(mr), .id_ex_rt_i(ert), .branch_taken_i(br),
    .mem_busy_i(busy), .clr_cnt_i(clr), .pc_write_o(pw_b),
    .if_id_hazard_o(hz_b), .if_id_flush_o(fl_b), .id_ex_bubble_o(bb_b),
    .stall_cnt_o(sc_b), .flush_cnt_o(fc_b));

  task automatic chk(input string tag, input longint got, input longint exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      rem[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
    end
  endtask

  // compare combinational outputs of both instances against model
  task automatic chk_outs(input string tag, input bit e_pw[2], input bit e_hz[2],
                          input bit e_fl[2], input bit e_bb[2]);
    chk({tag, "_pw_a"}, pw_a, e_pw[0]);
    chk({tag, "_hz_a"}, hz_a, e_hz[0]);
    chk({tag, "_fl_a"}, fl_a, e_fl[0]);
    chk({tag, "_bb_a"}, bb_a, e_bb[0]);
    chk({tag, "_pw_b"}, pw_b, e_pw[1]);
    chk({tag, "_hz_b"}, hz_b, e_hz[1]);
    chk({tag, "_fl_b"}, fl_b, e_fl[1]);
    chk({tag, "_bb_b"}, bb_b, e_bb[1]);
  endtask

  task automatic chk_cnts(input string tag);
    chk({tag, "_sc_a"}, sc_a, m_sc[0]);
    chk({tag, "_fc_a"}, fc_a, m_fc[0]);
    chk({tag, "_sc_b"}, sc_b, m_sc[1]);
    chk({tag, "_fc_b"}, fc_b, m_fc[1]);
  endtask

  // one clock cycle: called just after a rising edge, drives inputs,
  // checks outputs mid-cycle, advances the model at the next edge
  task automatic step(input string tag, input bit i_br, input bit i_busy,
                      input bit i_mr, input logic [4:0] i_rs,
                      input logic [4:0] i_rt, input logic [4:0] i_ert,
                      input bit i_clr);
    bit e_pw[2], e_hz[2], e_fl[2], e_bb[2];
    int nrem[2];
    bit lu;
    br = i_br; busy = i_busy; mr = i_mr; rs = i_rs; rt = i_rt; ert = i_ert;
    clr = i_clr;
    lu = i_mr && (i_ert != 0) && (i_ert == i_rs || i_ert == i_rt);
    for (int k = 0; k < 2; k++) begin
      e_pw[k] = 1; e_hz[k] = 0; e_fl[k] = 0; e_bb[k] = 0; nrem[k] = rem[k];
      if (i_busy) begin
        e_pw[k] = 0; e_hz[k] = 1;
      end else if (rem[k] > 0) begin
        e_fl[k] = 1; nrem[k] = rem[k] - 1;
      end else if (lu) begin
        e_pw[k] = 0; e_hz[k] = 1; e_bb[k] = 1;
      end else if (i_br) begin
        e_fl[k] = 1; nrem[k] = fcyc[k] - 1;
      end
    end
    #1;
    chk_outs(tag, e_pw, e_hz, e_fl, e_bb);
    if (e_hz[0] && e_fl[0]) chk({tag, "_excl"}, 1, 0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      rem[k] = nrem[k];
      if (i_clr) begin
        m_sc[k] = 0; m_fc[k] = 0;
      end else begin
        if (e_hz[k] && m_sc[k] < cmax[k]) m_sc[k]++;
        if (e_fl[k] && m_fc[k] < cmax[k]) m_fc[k]++;
      end
    end
    chk_cnts(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
  endtask

  initial begin
    rst = 1; rs = 0; rt = 0; ert = 0; mr = 0; br = 0; busy = 0; clr = 0;
    model_reset();
    @(posedge clk); #1;
    chk("rst_pw", pw_a, 1); chk("rst_hz", hz_a, 0);
    chk("rst_fl", fl_a, 0); chk("rst_bb", bb_a, 0);
    chk_cnts("rst");
    rst = 0;

    // 1: load r5, ID reads r5 -> one-cycle stall
    step("lu5", 0, 0, 1, 5'd5, 5'd1, 5'd5, 0);
    idle("lu5_after");
    chk("lu5_cnt", sc_a, 1);

    // 2: load r0 never stalls
    step("lu0", 0, 0, 1, 5'd0, 5'd0, 5'd0, 0);
    // load to rt-field match
    step("lu_rt", 0, 0, 1, 5'd2, 5'd7, 5'd7, 0);

    // 3: 3-cycle flush from one branch pulse
    step("clr3", 0, 0, 0, 5'd0, 5'd0, 5'd0, 1);
    step("br3", 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    idle("br3_f2");
    idle("br3_f3");
    idle("br3_end");
    chk("br3_cnt", fc_a, 3);

    // 4: busy for 2 cycles during the 2nd flush cycle
    step("clr4", 0, 0, 0, 5'd0, 5'd0, 5'd0, 1);
    step("br4", 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    step("busy4a", 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    step("busy4b", 0, 1, 1, 5'd3, 5'd0, 5'd3, 0);
    step("br4_f2", 1, 0, 1, 5'd3, 5'd0, 5'd3, 0);
    idle("br4_f3");
    idle("br4_end");
    chk("br4_cnt", fc_a, 3);

    // 5: load-use and branch same cycle -> stall only, then branch flushes
    step("lubr", 1, 0, 1, 5'd9, 5'd0, 5'd9, 0);
    step("lubr_re", 1, 0, 0, 5'd9, 5'd0, 5'd9, 0);
    idle("lubr_f2");
    idle("lubr_f3");

    // 6: counter saturation, clear beats increment, async reset mid-flush
    for (int i = 0; i < 20; i++) step("sat", 0, 0, 1, 5'd4, 5'd4, 5'd4, 0);
    chk("sat_cnt", sc_a, 15);
    step("clr_lu", 0, 0, 1, 5'd4, 5'd4, 5'd4, 1);
    chk("clr_lu_cnt", sc_a, 0);
    step("br_rst", 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    br = 0;
    rst = 1;
    #1;
    chk("arst_fl", fl_a, 0);
    chk("arst_pw", pw_a, 1);
    chk("arst_fc", fc_a, 0);
    chk("arst_sc", sc_a, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    idle("post_rst");

    // randomized traffic; small register range makes dependencies common
    for (int i = 0; i < 400; i++) begin
      step("rnd", ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 24) == 0));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
